// File: rtl/wb_shared_arbiter_if.sv
// Wishbone classic bus bundle between two masters, the shared arbiter and one slave.
// The slave modport is the arbiter's view; the master modport is the environment driving requests and slave responses.
interface wb_shared_arbiter_if;
  logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [7:0]  m_sel_i;
  logic [63:0] m_adr_i, m_dat_i;
  logic [1:0]  m_ack_o, m_err_o;
  logic [63:0] m_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );
endinterface

// File: rtl/wb_shared_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter: registered round-robin grant, locked for a whole cyc.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that error-terminates stalled slave transfers.
module wb_shared_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              clk_i,
  input logic              rst_i,
  wb_shared_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   own_v, own_idx;
  logic   err;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_shared_arbiter: TIMEOUT_CYCLES out of range 2..65535");
  end

  assign own_v   = (state_q != IDLE);
  assign own_idx = (state_q == GNT1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Grant only from IDLE, so every hand-over costs one idle bus cycle.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.m_cyc_i[0] && (!bus.m_cyc_i[1] || last_gnt_q)) begin
          state_d    = GNT0;
          last_gnt_d = 1'b0;
        end else if (bus.m_cyc_i[1]) begin
          state_d    = GNT1;
          last_gnt_d = 1'b1;
        end
      end
      GNT0:    if (!bus.m_cyc_i[0]) state_d = IDLE;
      GNT1:    if (!bus.m_cyc_i[1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_dat_o = '0;
    if (own_v) begin
      bus.s_cyc_o                         = bus.m_cyc_i[own_idx];
      bus.s_stb_o                         = bus.m_stb_i[own_idx];
      bus.s_we_o                          = bus.m_we_i[own_idx];
      bus.s_sel_o                         = bus.m_sel_i[{own_idx, 2'b00} +: 4];
      bus.s_adr_o                         = bus.m_adr_i[{own_idx, 5'b00000} +: 32];
      bus.s_dat_o                         = bus.m_dat_i[{own_idx, 5'b00000} +: 32];
      bus.m_ack_o[own_idx]                = bus.s_ack_i & bus.m_stb_i[own_idx] & ~err;
      bus.m_err_o[own_idx]                = err;
      bus.m_dat_o[{own_idx, 5'b00000} +: 32] = bus.s_dat_i;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Terminal count fires only when no ack arrives in the same cycle.
  assign err = own_v & bus.s_stb_o & ~bus.s_ack_i & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!own_v || !bus.s_stb_o || bus.s_ack_i || err) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_wb_shared_arbiter.sv
// Directed bench for wb_shared_arbiter: grant order, locking, idle gap, read mux, reset and watchdog.
module tb_wb_shared_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   errs = 0;

  localparam logic [31:0] A0 = 32'h1000_0000, A1 = 32'h2000_0000;
  localparam logic [31:0] D0 = 32'hA5A5_0000, D1 = 32'h5A5A_1111;

  wb_shared_arbiter_if bus ();

  wb_shared_arbiter #(.TIMEOUT_CYCLES(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, exp finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int n, input logic cyc, input logic stb, input logic we,
                       input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    bus.m_cyc_i[n]         = cyc;
    bus.m_stb_i[n]         = stb;
    bus.m_we_i[n]          = we;
    bus.m_sel_i[n*4 +: 4]  = sel;
    bus.m_adr_i[n*32 +: 32] = adr;
    bus.m_dat_i[n*32 +: 32] = dat;
  endtask

  task automatic test_reset();
    set_m(0, 1, 1, 1, 4'hF, A0, D0);
    set_m(1, 1, 1, 1, 4'hF, A1, D1);
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'hFFFF_FFFF;
    step();
    #1;
    if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b000) begin errs++; $display("FAIL rst_ctl: got %b exp 000", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}); end vec++;
    if ({bus.s_adr_o, bus.s_dat_o, bus.s_sel_o} !== 68'h0) begin errs++; $display("FAIL rst_bus: got %h exp 0", {bus.s_adr_o, bus.s_dat_o, bus.s_sel_o}); end vec++;
    if ({bus.m_ack_o, bus.m_err_o, bus.m_dat_o} !== 68'h0) begin errs++; $display("FAIL rst_resp: got %h exp 0", {bus.m_ack_o, bus.m_err_o, bus.m_dat_o}); end vec++;
    set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = 32'h0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    set_m(0, 1, 1, 1, 4'hF, A0, D0);
    set_m(1, 1, 1, 0, 4'h3, A1, D1);
    #1;
    if (bus.s_cyc_o !== 1'b0) begin errs++; $display("FAIL basic_latency: s_cyc got %b exp 0", bus.s_cyc_o); end vec++;
    step();
    if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o, bus.s_adr_o, bus.s_dat_o} !== {3'b111, 4'hF, A0, D0}) begin
      errs++; $display("FAIL basic_gnt0: got %h exp %h", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o, bus.s_adr_o, bus.s_dat_o}, {3'b111, 4'hF, A0, D0}); end vec++;
    bus.s_ack_i = 1'b1;
    #1;
    if (bus.m_ack_o !== 2'b01) begin errs++; $display("FAIL basic_ack0: got %b exp 01", bus.m_ack_o); end vec++;
    step();
    set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    #1;
    if (bus.s_cyc_o !== 1'b0) begin errs++; $display("FAIL basic_drop0: s_cyc got %b exp 0", bus.s_cyc_o); end vec++;
    step();
    if (bus.s_cyc_o !== 1'b0) begin errs++; $display("FAIL basic_idle_gap: s_cyc got %b exp 0", bus.s_cyc_o); end vec++;
    step();
    if ({bus.s_cyc_o, bus.s_we_o, bus.s_sel_o, bus.s_adr_o, bus.s_dat_o} !== {2'b10, 4'h3, A1, D1}) begin
      errs++; $display("FAIL basic_gnt1: got %h exp %h", {bus.s_cyc_o, bus.s_we_o, bus.s_sel_o, bus.s_adr_o, bus.s_dat_o}, {2'b10, 4'h3, A1, D1}); end vec++;
    bus.s_ack_i = 1'b1;
    #1;
    if (bus.m_ack_o !== 2'b10) begin errs++; $display("FAIL basic_ack1: got %b exp 10", bus.m_ack_o); end vec++;
    step();
    set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    logic [31:0] adr_e;
    logic [1:0]  ack_e;
    set_m(0, 1, 1, 1, 4'hF, A0, D0);
    set_m(1, 1, 1, 0, 4'h3, A1, D1);
    for (int i = 0; i < 8; i++) begin
      adr_e = (i % 2 == 0) ? A0 : A1;
      ack_e = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
      bus.s_ack_i = 1'b1;
      #1;
      if (bus.s_adr_o !== adr_e || bus.m_ack_o !== ack_e) begin
        errs++; $display("FAIL rr_xfer%0d: adr %h ack %b exp adr %h ack %b", i, bus.s_adr_o, bus.m_ack_o, adr_e, ack_e); end vec++;
      step();
      bus.m_cyc_i[i % 2] = 1'b0;
      bus.m_stb_i[i % 2] = 1'b0;
      bus.s_ack_i = 1'b0;
      #1;
      if (bus.s_cyc_o !== 1'b0) begin errs++; $display("FAIL rr_release%0d: s_cyc got %b exp 0", i, bus.s_cyc_o); end vec++;
      step();
      if (i < 6) begin
        bus.m_cyc_i[i % 2] = 1'b1;
        bus.m_stb_i[i % 2] = 1'b1;
      end
      #1;
      if (bus.s_cyc_o !== 1'b0) begin errs++; $display("FAIL rr_gap%0d: s_cyc got %b exp 0", i, bus.s_cyc_o); end vec++;
    end
    set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_lock();
    set_m(0, 1, 1, 1, 4'hF, A0, D0);
    set_m(1, 1, 1, 0, 4'h3, A1, D1);
    step();
    for (int b = 0; b < 3; b++) begin
      bus.m_adr_i[31:0] = A0 + 32'(4 * b);
      bus.s_ack_i = 1'b1;
      #1;
      if (bus.s_cyc_o !== 1'b1 || bus.s_adr_o !== A0 + 32'(4 * b) || bus.m_ack_o !== 2'b01) begin
        errs++; $display("FAIL lock_beat%0d: cyc %b adr %h ack %b exp cyc 1 adr %h ack 01", b, bus.s_cyc_o, bus.s_adr_o, bus.m_ack_o, A0 + 32'(4 * b)); end vec++;
      step();
    end
    bus.m_stb_i[0] = 1'b0;
    #1;
    if (bus.s_cyc_o !== 1'b1 || bus.m_ack_o !== 2'b00) begin
      errs++; $display("FAIL lock_nostb_ack: cyc %b ack %b exp cyc 1 ack 00", bus.s_cyc_o, bus.m_ack_o); end vec++;
    bus.m_cyc_i[0] = 1'b0;
    bus.s_ack_i = 1'b0;
    step();
    if (bus.s_cyc_o !== 1'b0) begin errs++; $display("FAIL lock_gap: s_cyc got %b exp 0", bus.s_cyc_o); end vec++;
    step();
    if (bus.s_adr_o !== A1 || bus.s_cyc_o !== 1'b1) begin errs++; $display("FAIL lock_next1: adr %h cyc %b exp %h 1", bus.s_adr_o, bus.s_cyc_o, A1); end vec++;
    set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    step();
    step();
  endtask

  task automatic test_read();
    set_m(1, 1, 1, 0, 4'hF, 32'h3000_0004, 32'h0);
    step();
    bus.s_dat_i = 32'hDEAD_BEEF;
    bus.s_ack_i = 1'b1;
    #1;
    if (bus.m_dat_o !== 64'hDEAD_BEEF_0000_0000) begin errs++; $display("FAIL read_dat: got %h exp deadbeef00000000", bus.m_dat_o); end vec++;
    if (bus.m_ack_o !== 2'b10 || bus.s_adr_o !== 32'h3000_0004 || bus.s_we_o !== 1'b0) begin
      errs++; $display("FAIL read_ctl: ack %b adr %h we %b exp 10 30000004 0", bus.m_ack_o, bus.s_adr_o, bus.s_we_o); end vec++;
    step();
    set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = 32'h0;
    step();
  endtask

  task automatic test_reset_mid();
    set_m(1, 1, 1, 0, 4'h3, A1, D1);
    step();
    if (bus.s_cyc_o !== 1'b1 || bus.s_adr_o !== A1) begin errs++; $display("FAIL rmid_pre: cyc %b adr %h exp 1 %h", bus.s_cyc_o, bus.s_adr_o, A1); end vec++;
    rst = 1'b1;
    #1;
    if ({bus.s_cyc_o, bus.s_stb_o} !== 2'b00) begin errs++; $display("FAIL rmid_async: got %b exp 00", {bus.s_cyc_o, bus.s_stb_o}); end vec++;
    step();
    rst = 1'b0;
    set_m(0, 1, 1, 1, 4'hF, A0, D0);
    #1;
    if (bus.s_cyc_o !== 1'b0) begin errs++; $display("FAIL rmid_idle: s_cyc got %b exp 0", bus.s_cyc_o); end vec++;
    step();
    if (bus.s_adr_o !== A0 || bus.s_cyc_o !== 1'b1) begin errs++; $display("FAIL rmid_gnt0: adr %h cyc %b exp %h 1", bus.s_adr_o, bus.s_cyc_o, A0); end vec++;
    set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    step();
    step();
  endtask

  task automatic test_timeout();
    set_m(0, 1, 1, 0, 4'hF, A0, 32'h0);
    step();
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 1; c <= 9; c++) begin
      #1;
      if (bus.m_err_o !== ((c == 8) ? 2'b01 : 2'b00) || bus.m_ack_o !== 2'b00) begin
        errs++; $display("FAIL to_stall_c%0d: err %b ack %b exp err %b ack 00", c, bus.m_err_o, bus.m_ack_o, (c == 8) ? 2'b01 : 2'b00); end vec++;
      step();
    end
    bus.m_stb_i[0] = 1'b0;
    step();
    bus.m_stb_i[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      bus.s_ack_i = (c == 8);
      #1;
      if (bus.m_err_o !== 2'b00 || bus.m_ack_o !== ((c == 8) ? 2'b01 : 2'b00)) begin
        errs++; $display("FAIL to_ackwins_c%0d: err %b ack %b exp err 00 ack %b", c, bus.m_err_o, bus.m_ack_o, (c == 8) ? 2'b01 : 2'b00); end vec++;
      step();
    end
`else
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (bus.m_err_o !== 2'b00) begin errs++; $display("FAIL no_timeout_c%0d: err %b exp 00", c, bus.m_err_o); end vec++;
      step();
    end
`endif
    set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    step();
    step();
  endtask

  initial begin
    set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = 32'h0;
    test_reset();
    test_basic();
    test_round_robin();
    test_lock();
    test_read();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
